// File: rtl/regfile_debug_master.sv
// regfile_debug_master: debug/boot initiator that bulk-loads or dumps the 8x8 register file.
//   Command:  CMD_VALID/CMD_READY handshake, CMD_OP (0=load, 1=dump), CMD_ADDR start, CMD_COUNT (clamped to 8)
//   Load in:  DIN/DIN_VALID/DIN_READY byte stream written via RF_IN/RF_INADDR/RF_WRITE
//   Dump out: RF_OUTADDR/RF_OUT read, streamed on DOUT/DOUT_VALID/DOUT_READY
//   Status:   BUSY outside IDLE, DONE one-cycle pulse on completion; all outputs registered
module regfile_debug_master #(
  parameter int READ_SETTLE = 1
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic       CMD_OP,
  input  logic [2:0] CMD_ADDR,
  input  logic [3:0] CMD_COUNT,
  input  logic [7:0] DIN,
  input  logic       DIN_VALID,
  output logic       DIN_READY,
  output logic [7:0] DOUT,
  output logic       DOUT_VALID,
  input  logic       DOUT_READY,
  output logic [7:0] RF_IN,
  output logic [2:0] RF_INADDR,
  output logic       RF_WRITE,
  output logic [2:0] RF_OUTADDR,
  input  logic [7:0] RF_OUT,
  output logic       BUSY,
  output logic       DONE
);
  localparam logic [2:0] IDLE = 3'd0, LD_WAIT = 3'd1, LD_WR = 3'd2, DP_ADDR = 3'd3,
                         DP_SETTLE = 3'd4, DP_SEND = 3'd5, FIN = 3'd6;
  logic [2:0] state_q, state_d, addr_q, addr_d, settle_q, settle_d;
  logic [2:0] rf_inaddr_q, rf_inaddr_d, rf_outaddr_q, rf_outaddr_d;
  logic [3:0] rem_q, rem_d;
  logic [7:0] dout_q, dout_d, rf_in_q, rf_in_d;
  logic cmd_ready_q, cmd_ready_d, din_ready_q, din_ready_d, dout_valid_q, dout_valid_d;
  logic rf_write_q, rf_write_d, busy_q, busy_d, done_q, done_d;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    rem_d = rem_q;
    settle_d = settle_q;
    rf_in_d = rf_in_q;
    rf_inaddr_d = rf_inaddr_q;
    rf_outaddr_d = rf_outaddr_q;
    dout_d = dout_q;
    dout_valid_d = dout_valid_q;
    cmd_ready_d = cmd_ready_q;
    din_ready_d = din_ready_q;
    busy_d = busy_q;
    rf_write_d = 1'b0;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (CMD_VALID) begin
        addr_d = CMD_ADDR;
        rem_d = (CMD_COUNT > 4'd8) ? 4'd8 : CMD_COUNT;
        cmd_ready_d = 1'b0;
        busy_d = 1'b1;
        state_d = (CMD_COUNT == 4'd0) ? FIN : CMD_OP ? DP_ADDR : LD_WAIT;
        done_d = CMD_COUNT == 4'd0;
        din_ready_d = CMD_COUNT != 4'd0 && !CMD_OP;
      end
      LD_WAIT: if (DIN_VALID) begin
        rf_in_d = DIN;
        rf_inaddr_d = addr_q;
        rf_write_d = 1'b1;
        din_ready_d = 1'b0;
        state_d = LD_WR;
      end
      LD_WR: begin
        addr_d = addr_q + 3'd1;
        rem_d = rem_q - 4'd1;
        state_d = (rem_q == 4'd1) ? FIN : LD_WAIT;
        done_d = rem_q == 4'd1;
        din_ready_d = rem_q != 4'd1;
      end
      DP_ADDR: begin
        rf_outaddr_d = addr_q;
        settle_d = 3'(READ_SETTLE);
        state_d = DP_SETTLE;
      end
      // RF_OUT is sampled once RF_OUTADDR has been stable for READ_SETTLE cycles
      DP_SETTLE: begin
        settle_d = settle_q - 3'd1;
        if (settle_q <= 3'd1) begin
          dout_d = RF_OUT;
          dout_valid_d = 1'b1;
          state_d = DP_SEND;
        end
      end
      DP_SEND: if (DOUT_READY) begin
        dout_valid_d = 1'b0;
        addr_d = addr_q + 3'd1;
        rem_d = rem_q - 4'd1;
        state_d = (rem_q == 4'd1) ? FIN : DP_ADDR;
        done_d = rem_q == 4'd1;
      end
      default: begin
        state_d = IDLE;
        busy_d = 1'b0;
        cmd_ready_d = 1'b1;
        din_ready_d = 1'b0;
        dout_valid_d = 1'b0;
      end
    endcase
  end
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= IDLE;
      addr_q <= '0;
      rem_q <= '0;
      settle_q <= '0;
      rf_in_q <= '0;
      rf_inaddr_q <= '0;
      rf_outaddr_q <= '0;
      dout_q <= '0;
      dout_valid_q <= 1'b0;
      cmd_ready_q <= 1'b1;
      din_ready_q <= 1'b0;
      rf_write_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      rem_q <= rem_d;
      settle_q <= settle_d;
      rf_in_q <= rf_in_d;
      rf_inaddr_q <= rf_inaddr_d;
      rf_outaddr_q <= rf_outaddr_d;
      dout_q <= dout_d;
      dout_valid_q <= dout_valid_d;
      cmd_ready_q <= cmd_ready_d;
      din_ready_q <= din_ready_d;
      rf_write_q <= rf_write_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign CMD_READY = cmd_ready_q;
  assign DIN_READY = din_ready_q;
  assign DOUT = dout_q;
  assign DOUT_VALID = dout_valid_q;
  assign RF_IN = rf_in_q;
  assign RF_INADDR = rf_inaddr_q;
  assign RF_WRITE = rf_write_q;
  assign RF_OUTADDR = rf_outaddr_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
endmodule

// File: tb/tb_regfile_debug_master.sv
// tb_regfile_debug_master: directed bench with a behavioural 8x8 register file beside the DUT.
module tb_regfile_debug_master;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_op = 1'b0, din_valid = 1'b0, dout_ready = 1'b0;
  logic [2:0] cmd_addr = '0;
  logic [3:0] cmd_count = '0;
  logic [7:0] din = '0;
  logic cmd_ready, din_ready, dout_valid, rf_write, busy, done;
  logic [7:0] dout, rf_in, rf_out;
  logic [2:0] rf_inaddr, rf_outaddr;
  logic [7:0] rf [8];
  logic [2:0] wlog [64];
  logic [7:0] dlog [64];
  int wn = 0, dn = 0, done_n = 0, tests = 0, fails = 0;
  always #5 clk = ~clk;
  regfile_debug_master #(.READ_SETTLE(1)) dut (
    .CLOCK(clk), .RESET(rst), .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_OP(cmd_op),
    .CMD_ADDR(cmd_addr), .CMD_COUNT(cmd_count), .DIN(din), .DIN_VALID(din_valid),
    .DIN_READY(din_ready), .DOUT(dout), .DOUT_VALID(dout_valid), .DOUT_READY(dout_ready),
    .RF_IN(rf_in), .RF_INADDR(rf_inaddr), .RF_WRITE(rf_write), .RF_OUTADDR(rf_outaddr),
    .RF_OUT(rf_out), .BUSY(busy), .DONE(done)
  );
  assign rf_out = rf[rf_outaddr];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else begin
      if (rf_write) begin
        rf[rf_inaddr] <= rf_in;
        wlog[wn % 64] <= rf_inaddr;
        wn <= wn + 1;
      end
      if (dout_valid && dout_ready) begin
        dlog[dn % 64] <= dout;
        dn <= dn + 1;
      end
      if (done) done_n <= done_n + 1;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic send_cmd(input logic op, input logic [2:0] a, input logic [3:0] n);
    cmd_op = op;
    cmd_addr = a;
    cmd_count = n;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask
  task automatic load_byte(input string tag, input logic [7:0] b, input logic [2:0] a);
    int k = 0;
    while (!din_ready && k < 50) begin
      tick();
      k++;
    end
    if (k == 50) chk({tag, "_din_ready_timeout"}, 0, 1);
    din = b;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    chk({tag, "_wr"}, {din_ready, rf_write, rf_inaddr, rf_in}, {1'b0, 1'b1, a, b});
  endtask
  task automatic wait_done(input string tag);
    int k = 0;
    while (!done && k < 200) begin
      tick();
      k++;
    end
    if (k == 200) chk({tag, "_done_timeout"}, 0, 1);
    chk({tag, "_fin"}, {busy, cmd_ready}, 2'b10);
    tick();
    chk({tag, "_idle"}, {done, busy, cmd_ready}, 3'b001);
  endtask
  task automatic stall_byte(input string tag, input logic [7:0] exp);
    int k = 0;
    while (!dout_valid && k < 20) begin
      tick();
      k++;
    end
    if (k == 20) chk({tag, "_valid_timeout"}, 0, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk({tag, "_hold"}, {dout_valid, dout}, {1'b1, exp});
    end
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    chk({tag, "_drop"}, dout_valid, 0);
  endtask
  initial begin
    int w0, d0, n0;
    repeat (2) tick();
    rst = 1'b0;
    chk("reset_ctrl", {cmd_ready, busy, done, din_ready, dout_valid, rf_write}, 6'b100000);
    chk("reset_data", {dout, rf_in, rf_inaddr, rf_outaddr}, 22'h0);
    w0 = wn; n0 = done_n;
    send_cmd(1'b0, 3'd6, 4'd3);
    load_byte("ld1", 8'h11, 3'd6);
    load_byte("ld2", 8'h22, 3'd7);
    load_byte("ld3", 8'h33, 3'd0);
    wait_done("ld");
    chk("ld_writes", wn - w0, 3);
    chk("ld_addrs", {wlog[w0], wlog[w0 + 1], wlog[w0 + 2]}, {3'd6, 3'd7, 3'd0});
    chk("ld_regs", {rf[6], rf[7], rf[0]}, 24'h112233);
    chk("ld_done", done_n - n0, 1);
    d0 = dn; n0 = done_n;
    dout_ready = 1'b1;
    send_cmd(1'b1, 3'd6, 4'd3);
    wait_done("dp");
    dout_ready = 1'b0;
    chk("dp_bytes", {dlog[d0], dlog[d0 + 1], dlog[d0 + 2]}, 24'h112233);
    chk("dp_count", dn - d0, 3);
    chk("dp_done", done_n - n0, 1);
    w0 = wn; d0 = dn;
    send_cmd(1'b0, 3'd5, 4'd0);
    chk("z_done_pulse", done, 1);
    wait_done("z");
    chk("z_no_xfer", {wn - w0, dn - d0}, 0);
    w0 = wn; n0 = done_n;
    send_cmd(1'b0, 3'd2, 4'd4);
    load_byte("rs1", 8'h44, 3'd2);
    load_byte("rs2", 8'h55, 3'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rs_state", {rf_write, cmd_ready, busy, done, din_ready}, 5'b01000);
    tick();
    chk("rs_no_done", done_n - n0, 0);
    chk("rs_rf_cleared", {rf[2], rf[3]}, 16'h0);
    send_cmd(1'b0, 3'd3, 4'd2);
    load_byte("nl1", 8'h5a, 3'd3);
    load_byte("nl2", 8'ha5, 3'd4);
    wait_done("nl");
    chk("nl_regs", {rf[3], rf[4]}, 16'h5aa5);
    w0 = wn;
    send_cmd(1'b0, 3'd0, 4'd12);
    for (int i = 0; i < 8; i++) load_byte("cl", 8'ha0 + 8'(i), 3'(i));
    wait_done("cl");
    chk("cl_writes", wn - w0, 8);
    chk("cl_regs_lo", {rf[0], rf[1], rf[2], rf[3]}, 32'ha0a1a2a3);
    chk("cl_regs_hi", {rf[4], rf[5], rf[6], rf[7]}, 32'ha4a5a6a7);
    d0 = dn;
    send_cmd(1'b1, 3'd7, 4'd2);
    stall_byte("st1", 8'ha7);
    stall_byte("st2", 8'ha0);
    wait_done("st");
    chk("st_bytes", {dlog[d0], dlog[d0 + 1]}, 16'ha7a0);
    w0 = wn; d0 = dn; n0 = done_n;
    din = 8'hff;
    din_valid = 1'b1;
    dout_ready = 1'b1;
    send_cmd(1'b1, 3'd2, 4'd3);
    send_cmd(1'b0, 3'd0, 4'd1);
    wait_done("ig");
    din_valid = 1'b0;
    dout_ready = 1'b0;
    chk("ig_bytes", {dlog[d0], dlog[d0 + 1], dlog[d0 + 2]}, 24'ha2a3a4);
    chk("ig_no_write", wn - w0, 0);
    repeat (3) tick();
    chk("ig_not_queued", {busy, done_n - n0}, {1'b0, 32'd1});
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
